// File: rtl/prbs8_pkg.sv
// prbs8_pkg
//   Shared definitions for the 8-bit PRBS checker and future generator
//   variants: FSM state encoding, LFSR width, tap mask, default seed and
//   the feedback function. The polynomial is x^8+x^6+x^5+x^4+1, which uses
//   taps 7,5,4,3 and gives period 255.
//   Optional feature macro used by the checker: PRBS8_CHK_BITCNT_EN.
//   No ports (package).

package prbs8_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int PRBS8_W = 8;
  localparam logic [PRBS8_W-1:0] PRBS8_TAPS = 8'hB8;
  localparam logic [PRBS8_W-1:0] PRBS8_SEED = 8'h01;

  // Fibonacci feedback: XOR of the tapped state bits.
  function automatic logic prbs8_fb(input logic [PRBS8_W-1:0] s);
    return ^(s & PRBS8_TAPS);
  endfunction

endpackage

// File: rtl/prbs8_lfsr_step.sv
// prbs8_lfsr_step
//   One combinational step of the 8-bit Fibonacci LFSR. It reports the bit
//   the sequence predicts next and the state after shifting in a chosen bit.
//   The caller picks which bit to shift, so the same block serves a
//   generator and a checker.
// Ports
//   s_i    in  8  current LFSR state, bit 0 is the newest bit
//   b_i    in  1  bit to shift in
//   s_o    out 8  state after the shift, {s_i[6:0], b_i}
//   exp_o  out 1  predicted next bit for state s_i

module prbs8_lfsr_step
  import prbs8_pkg::*;
(
  input  logic [PRBS8_W-1:0] s_i,
  input  logic               b_i,
  output logic [PRBS8_W-1:0] s_o,
  output logic               exp_o
);

  assign exp_o = prbs8_fb(s_i);
  assign s_o   = {s_i[PRBS8_W-2:0], b_i};

endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker
//   Receive-side checker for the 8-bit PRBS stream. It fills a local LFSR
//   from the incoming bits (HUNT), confirms the prediction holds for
//   LOCK_THRESH bits (VERIFY), then flywheels the local LFSR and counts
//   every mismatching bit (LOCKED). LOSS_THRESH consecutive misses drop lock.
//   Optional feature: define PRBS8_CHK_BITCNT_EN to add bit_count_o, a
//   saturating count of bits checked while locked.
// Ports
//   clk_i        in  1          clock, everything on the rising edge
//   reset_i      in  1          synchronous active-high reset
//   i_i          in  1          received serial bit, used only when valid_i=1
//   valid_i      in  1          qualifies i_i; when low all state except the
//                               counter clear is frozen
//   clr_err_i    in  1          synchronous clear of the counters
//   locked_o     out 1          high while the FSM is in LOCKED
//   err_o        out 1          one-cycle pulse after a locked mismatch
//   err_count_o  out ERR_CNT_W  saturating count of locked mismatches
//   o_o          out 8          local LFSR state, bit 0 is the newest bit
//   bit_count_o  out 32         (PRBS8_CHK_BITCNT_EN only) locked bits checked

module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 i_i,
  input  logic                 valid_i,
  input  logic                 clr_err_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [PRBS8_W-1:0]   o_o
`ifdef PRBS8_CHK_BITCNT_EN
  ,
  output logic [31:0]          bit_count_o
`endif
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  state_t               state_q;
  logic [PRBS8_W-1:0]   s_q;
  logic [PRBS8_W-1:0]   sNext_d;
  logic [2:0]           fillCnt_q;
  logic [MATCH_W-1:0]   matchCnt_q;
  logic [MISS_W-1:0]    missCnt_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] errCount_q;

  logic exp_d;
  logic shiftBit_d;
  logic mismatch_d;
  logic checkBit_d;
  logic countErr_d;

  // Once locked we shift the prediction rather than the received bit, so a
  // single corrupted bit costs exactly one error instead of poisoning the
  // next eight predictions.
  assign shiftBit_d = (state_q == LOCKED) ? exp_d : i_i;

  prbs8_lfsr_step u_step (
    .s_i   (s_q),
    .b_i   (shiftBit_d),
    .s_o   (sNext_d),
    .exp_o (exp_d)
  );

  assign mismatch_d = i_i ^ exp_d;
  assign checkBit_d = valid_i && (state_q == LOCKED);
  assign countErr_d = checkBit_d && mismatch_d;

  // Lock FSM together with the LFSR and its fill/match/miss counters. An
  // all-zero LFSR is a lockup state the generator never produces, so it is
  // sent back to HUNT instead of being verified.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= HUNT;
      s_q        <= '0;
      fillCnt_q  <= '0;
      matchCnt_q <= '0;
      missCnt_q  <= '0;
    end else if (valid_i) begin
      s_q <= sNext_d;
      case (state_q)
        HUNT: begin
          if (fillCnt_q == 3'd7) begin
            fillCnt_q <= '0;
            if (sNext_d != '0) begin
              state_q    <= VERIFY;
              matchCnt_q <= '0;
            end
          end else begin
            fillCnt_q <= fillCnt_q + 3'd1;
          end
        end
        VERIFY: begin
          if (!mismatch_d) begin
            if (matchCnt_q == MATCH_W'(LOCK_THRESH - 1)) begin
              state_q    <= LOCKED;
              matchCnt_q <= '0;
              missCnt_q  <= '0;
            end else begin
              matchCnt_q <= matchCnt_q + 1'b1;
            end
          end else begin
            matchCnt_q <= '0;
            if (sNext_d == '0) begin
              state_q   <= HUNT;
              fillCnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (mismatch_d) begin
            if (missCnt_q == MISS_W'(LOSS_THRESH - 1)) begin
              state_q   <= HUNT;
              fillCnt_q <= '0;
              missCnt_q <= '0;
            end else begin
              missCnt_q <= missCnt_q + 1'b1;
            end
          end else begin
            missCnt_q <= '0;
          end
        end
        default: begin
          state_q   <= HUNT;
          fillCnt_q <= '0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter. A clear that coincides with a
  // counted error leaves 1, so that error is never lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q      <= 1'b0;
      errCount_q <= '0;
    end else begin
      err_q <= countErr_d;
      if (clr_err_i) begin
        errCount_q <= {{(ERR_CNT_W-1){1'b0}}, countErr_d};
      end else if (countErr_d && (errCount_q != '1)) begin
        errCount_q <= errCount_q + 1'b1;
      end
    end
  end

`ifdef PRBS8_CHK_BITCNT_EN
  logic [31:0] bitCount_q;

  // Count of bits checked while locked, saturating, with the same clear rule
  // as the error counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bitCount_q <= '0;
    end else if (clr_err_i) begin
      bitCount_q <= {31'd0, checkBit_d};
    end else if (checkBit_d && (bitCount_q != '1)) begin
      bitCount_q <= bitCount_q + 32'd1;
    end
  end

  assign bit_count_o = bitCount_q;
`endif

  assign locked_o    = (state_q == LOCKED);
  assign err_o       = err_q;
  assign err_count_o = errCount_q;
  assign o_o         = s_q;

endmodule
